// File: rtl/clk_meter_pkg.sv
// Shared definitions for the slow-clock period meter: state encoding and default sizing.
package clk_meter_pkg;

    localparam int unsigned CNT_W_DEF      = 32;
    localparam logic [31:0] NOMINAL_PERIOD = 32'd1_600_000;
    localparam logic [31:0] TIMEOUT_DEF    = 32'd3_200_000;
    localparam logic [31:0] TOL_DEF        = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED,
        LOST
    } meter_state_e;

endpackage

// File: rtl/clk_period_meter_sync_edge_detect.sv
// Two-flop synchroniser followed by an edge register; emits the synchronised level and a
// one-cycle pulse on each rising edge. Generic enough to reuse for keypad inputs.
module sync_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of a slow asynchronous clock in system-clock cycles, tracks lock and loss.
// Optional high-time measurement is enabled with `define CLK_PERIOD_METER_DUTY_EN.
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int unsigned      CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_DEF),
    parameter logic [CNT_W-1:0] TOL     = CNT_W'(TOL_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] max_count_est,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
`ifdef CLK_PERIOD_METER_DUTY_EN
    ,
    output logic [CNT_W-1:0] high_time
`endif
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    logic             w_rise;
`ifdef CLK_PERIOD_METER_DUTY_EN
    logic             w_level;
`else
    logic             w_level_unused;
`endif

    meter_state_e     r_state;
    meter_state_e     w_state_next;
    logic             r_have_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_mce;
    logic             r_valid;

    logic [CNT_W-1:0] w_new_period;
    logic [CNT_W-1:0] w_new_mce;
    logic [CNT_W-1:0] w_diff;
    logic             w_in_tol;
    logic             w_timeout;
    logic             w_publish;

    sync_edge_detect u_sync (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_async (sclk_in),
`ifdef CLK_PERIOD_METER_DUTY_EN
        .o_level (w_level),
`else
        .o_level (w_level_unused),
`endif
        .o_rise  (w_rise)
    );

    // A rise closes the interval that started at the previous rise, so period is cnt + 1.
    assign w_new_period = r_cnt + ONE;
    assign w_new_mce    = (w_new_period < TWO) ? '0 : (w_new_period >> 1) - ONE;
    assign w_diff       = (w_new_period >= r_period) ? (w_new_period - r_period)
                                                     : (r_period - w_new_period);
    assign w_in_tol     = (w_diff <= TOL);
    assign w_timeout    = (r_cnt >= TIMEOUT - ONE);

    // A rise always takes priority over a timeout landing in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_publish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_next = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (w_rise) begin
                    w_publish = 1'b1;
                    if (r_have_prev && w_in_tol) begin
                        w_state_next = LOCKED;
                    end
                end else if (w_timeout) begin
                    w_state_next = LOST;
                end
            end
            LOCKED: begin
                if (w_rise) begin
                    w_publish = 1'b1;
                    if (!w_in_tol) begin
                        w_state_next = ACQUIRE;
                    end
                end else if (w_timeout) begin
                    w_state_next = LOST;
                end
            end
            LOST: begin
                if (w_rise) begin
                    w_state_next = ACQUIRE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_have_prev <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_publish) begin
                r_have_prev <= 1'b1;
            end else if (w_state_next == LOST) begin
                r_have_prev <= 1'b0;
            end
        end
    end

    // Held at zero while idle so the first rise only starts the measurement.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == IDLE || w_rise) begin
            r_cnt <= '0;
        end else if (r_cnt < TIMEOUT) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_period <= '0;
            r_mce    <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_publish;
            if (w_publish) begin
                r_period <= w_new_period;
                r_mce    <= w_new_mce;
            end
        end
    end

`ifdef CLK_PERIOD_METER_DUTY_EN
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_high_time;

    // The rise cycle itself is high but is not counted by the counter, hence the + 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_high_cnt  <= '0;
            r_high_time <= '0;
        end else begin
            if (w_rise) begin
                r_high_cnt <= '0;
            end else if (w_level && r_high_cnt < TIMEOUT) begin
                r_high_cnt <= r_high_cnt + ONE;
            end
            if (w_publish) begin
                r_high_time <= r_high_cnt + ONE;
            end
        end
    end

    assign high_time = r_high_time;
`endif

    assign period        = r_period;
    assign max_count_est = r_mce;
    assign period_valid  = r_valid;
    assign locked        = (r_state == LOCKED);
    assign lost          = (r_state == LOST);

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period of a slow square-wave clock (such as the divided display/scan clock) in cycles of the 100 MHz system clock, and recovers the divider's MAX_COUNT setting from it. Sits in the 100 MHz domain as the receiving end of a divided clock: it synchronises the slow signal, timestamps its rising edges, and reports period, lock status and loss of clock. Used for self-check of divider settings and for the on-board diagnostic display.

## Interface
- CNT_W, 32, width of all counters and measured values
- TIMEOUT, 32'd3_200_000, cycles without a rising edge before the clock is declared lost (2 × the 1.6 M-cycle nominal period)
- TOL, 32'd4, maximum absolute difference, in cycles, between consecutive periods for lock
- clk  input  1  100 MHz system clock
- rst  input  1  reset; synchronous and active-high
- sclk_in  input  1  slow clock under measurement; asynchronous to clk
- period  output  CNT_W  last completed period in clk cycles; reset 0
- max_count_est  output  CNT_W  (period >> 1) − 1, or 0 when period < 2; reset 0
- period_valid  output  1  one-cycle pulse when period/max_count_est update; reset 0
- locked  output  1  two consecutive periods within TOL; reset 0
- lost  output  1  no rising edge for TIMEOUT cycles; reset 0

## Operation
- sclk_in passes through a 2-flop synchroniser (s1, s2) plus an edge register s3; rise = s2 & ~s3.
- Cycle counter cnt: cleared to 0 in the rise cycle, else increments, saturating at TIMEOUT.
- Measured period = cnt + 1 at a rise, i.e. exact clk-cycle count between consecutive detected rises.
- States: IDLE, ACQUIRE, LOCKED, LOST. Reset → IDLE.
  - IDLE: cnt held 0. rise → ACQUIRE, no period_valid (no start reference).
  - ACQUIRE: rise → publish period, pulse period_valid; if a previous period exists (have_prev) and |new − prev| ≤ TOL → LOCKED; set have_prev.
  - LOCKED: rise → publish, pulse period_valid; |new − prev| > TOL → ACQUIRE, locked drops the same cycle period updates.
  - ACQUIRE/LOCKED: cnt reaches TIMEOUT → LOST; lost=1, locked=0, have_prev cleared, period/max_count_est retained.
  - LOST: rise → ACQUIRE, lost=0, cnt cleared, no period_valid (partial interval discarded).
- Difference computed unsigned as max − min, CNT_W bits; no overflow since values ≤ TIMEOUT.
- Rise and timeout in the same cycle: rise wins (period published, no LOST).
- locked = (state == LOCKED); lost = (state == LOST); both registered.

## Timing
- Edge latency: sclk_in rising → rise asserted 2–3 clk cycles later (synchroniser + edge register).
- period, max_count_est, period_valid, locked all update in the cycle after rise is asserted (one register stage).
- Lost declared on the cycle cnt reaches TIMEOUT, i.e. TIMEOUT cycles after the last rise.
- rst asserted mid-measurement: all state, synchroniser flops and outputs return to reset values on the next clk edge; first rise after release is treated as the IDLE start edge.
- Minimum measurable period: 4 clk cycles (synchroniser limit); shorter periods produce undefined values but no lock-up.

## Configuration
- CLK_PERIOD_METER_DUTY_EN defined: extra output high_time (CNT_W, reset 0) = clk cycles s2 was high in the last completed period, updated with period_valid; a second counter cleared on rise, incrementing while s2=1.
- Undefined: no high_time port, no second counter; all other behaviour identical.

## Structure
- Shared package clk_meter_pkg: state enum (IDLE, ACQUIRE, LOCKED, LOST), default CNT_W, nominal period constant 32'd1_600_000 and TIMEOUT default.
- One natural sub-module: sync_edge_detect (2-flop synchroniser + rising-edge pulse), reusable for keypad inputs.

## Test plan
- Square wave period 10 cycles (5 high/5 low), TIMEOUT=100, TOL=0 → first rise no valid; second rise period=10, max_count_est=4; third rise locked=1.
- Period switches 10 → 16 while LOCKED, TOL=2 → next valid period=16, locked=0 same cycle; one further 16 period → locked=1, max_count_est=7.
- Stop sclk_in low after lock, TIMEOUT=100 → lost=1, locked=0 exactly 100 cycles after last rise; period stays 10; resume → first rise no valid, lost=0.
- rst pulsed 3 cycles into a period → all outputs 0, state IDLE; next two rises give one valid only on the second.
- Jitter 10/11/10/11, TOL=1 → locked holds 1 throughout; TOL=0 → locked never asserts.
- With CLK_PERIOD_METER_DUTY_EN: 3 high/7 low → high_time=3, period=10 on each valid.
